// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback stage and register file.
package wb_regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

   localparam word_t    WORD_ZERO = '0;
   localparam reg_idx_t REG_ZERO  = '0;

   // Writeback source select carried by mem_to_reg.
   typedef enum logic {
      WB_SEL_ALU = 1'b0,
      WB_SEL_MEM = 1'b1
   } wb_sel_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback fields plus the ID-stage read ports of the register file.
interface wb_regfile_if;
   import wb_regfile_pkg::*;

   logic     reg_write_wb;
   logic     mem_to_reg_wb;
   word_t    read_data_wb;
   word_t    alu_result_wb;
   reg_idx_t dst_wb;
   reg_idx_t rs_addr;
   reg_idx_t rt_addr;
   word_t    rs_data;
   word_t    rt_data;
   word_t    wb_data;

   // Pipeline side: supplies writeback fields and read indices.
   modport master (
      output reg_write_wb, mem_to_reg_wb, read_data_wb, alu_result_wb, dst_wb,
      output rs_addr, rt_addr,
      input  rs_data, rt_data, wb_data
   );

   // Register file side.
   modport slave (
      input  reg_write_wb, mem_to_reg_wb, read_data_wb, alu_result_wb, dst_wb,
      input  rs_addr, rt_addr,
      output rs_data, rt_data, wb_data
   );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 writeback select: load data or ALU result. Shared with EX forwarding.
module wb_mux
   import wb_regfile_pkg::*;
(
   input  wb_sel_e sel,
   input  word_t   mem_data,
   input  word_t   alu_data,
   output word_t   wb_data
);

   assign wb_data = (sel == WB_SEL_MEM) ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file with write-to-read
// bypass, a no-bypass debug port and a retired-write counter.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus,
   input  reg_idx_t     dbg_addr,
   output word_t        dbg_data,
   output logic [31:0]  wb_count
);

   word_t       regs_q [NREGS];
   logic [31:0] wb_count_q;
   word_t       wb_value;
   logic        commit;

   wb_mux u_wb_mux (
      .sel      (wb_sel_e'(bus.mem_to_reg_wb)),
      .mem_data (bus.read_data_wb),
      .alu_data (bus.alu_result_wb),
      .wb_data  (wb_value)
   );

   assign bus.wb_data = wb_value;

   // A write retires only when enabled and not aimed at the hardwired r0.
   assign commit = bus.reg_write_wb && (bus.dst_wb != REG_ZERO);

   // Register array: cleared by reset, written with the selected value on commit.
   // NOTE: this array is flops, not a RAM macro, so it can and must take the
   // reset -- the ID stage expects every register to read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            // NOTE: non-blocking in clocked blocks so every flop samples
            // pre-edge values regardless of statement order.
            regs_q[i] <= WORD_ZERO;
         end
      end else if (commit) begin
         regs_q[bus.dst_wb] <= wb_value;
      end
   end

   // Retired-write counter, free-running modulo 2**32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_count_q <= '0;
      end else if (commit) begin
         wb_count_q <= wb_count_q + 32'd1;
      end
   end

   // Read ports: r0 reads zero, a same-cycle commit is bypassed, else the array.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch forms.
      bus.rs_data = regs_q[bus.rs_addr];
      bus.rt_data = regs_q[bus.rt_addr];
      if (bus.rs_addr == REG_ZERO) begin
         bus.rs_data = WORD_ZERO;
      end else if (commit && (bus.rs_addr == bus.dst_wb)) begin
         bus.rs_data = wb_value;
      end
      if (bus.rt_addr == REG_ZERO) begin
         bus.rt_data = WORD_ZERO;
      end else if (commit && (bus.rt_addr == bus.dst_wb)) begin
         bus.rt_data = wb_value;
      end
   end

   // Debug view of the stored array only; r0 is never written so it stays zero.
   assign dbg_data = regs_q[dbg_addr];
   assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array/counter reference model.
module tb_wb_regfile;
   import wb_regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   reg_idx_t    dbg_addr;
   word_t       dbg_data;
   logic [31:0] wb_count;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural register contents and retired-write count.
   word_t       model [NREGS];
   logic [31:0] exp_count;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wb_count (wb_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   function automatic word_t exp_wb();
      return bus.mem_to_reg_wb ? bus.read_data_wb : bus.alu_result_wb;
   endfunction

   // What ID should see this cycle: r0 is zero, a pending write is visible, else stored.
   function automatic word_t exp_read(input reg_idx_t a);
      if (a == 5'd0) return 32'h0;
      if (bus.reg_write_wb && bus.dst_wb == a) return exp_wb();
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
      exp_count = 32'h0;
   endtask

   task automatic drive(input logic rw, input logic m2r, input word_t rd,
                        input word_t alu, input reg_idx_t dst);
      bus.reg_write_wb  = rw;
      bus.mem_to_reg_wb = m2r;
      bus.read_data_wb  = rd;
      bus.alu_result_wb = alu;
      bus.dst_wb        = dst;
   endtask

   // Advance one clock; the model retires the write the DUT should commit.
   task automatic tick();
      if (!rst && bus.reg_write_wb && bus.dst_wb != 5'd0) begin
         model[bus.dst_wb] = exp_wb();
         exp_count = exp_count + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h0, 32'h1111_2222, 5'd9);
      tick();
      drive(1'b1, 1'b1, 32'h3333_4444, 32'h0, 5'd20);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #2;
      rst = 1'b1;
      clear_model();
      #1;
      checks++;
      if (wb_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_count: got %h expected %h", wb_count, 32'h0);
      end
      for (int i = 0; i < NREGS; i++) begin
         bus.rs_addr = reg_idx_t'(i);
         bus.rt_addr = reg_idx_t'(NREGS - 1 - i);
         dbg_addr    = reg_idx_t'(i);
         #1;
         checks++;
         if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read[%0d]: got rs=%h rt=%h dbg=%h expected 0",
                     i, bus.rs_data, bus.rt_data, dbg_data);
         end
      end
      // A write presented while reset is held must not land.
      drive(1'b1, 1'b0, 32'h0, 32'h0BAD_0BAD, 5'd9);
      @(posedge clk);
      #1;
      dbg_addr = 5'd9;
      #1;
      checks++;
      if (dbg_data !== 32'h0 || wb_count !== 32'h0) begin
         errors++;
         $display("FAIL reset_blocks_write: got r9=%h count=%h expected 0", dbg_data, wb_count);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu_writeback();
      drive(1'b1, 1'b0, $urandom, 32'h0000_1234, 5'd5);
      bus.rs_addr = 5'd5;
      bus.rt_addr = 5'd6;
      dbg_addr    = 5'd5;
      #1;
      checks++;
      if (bus.rs_data !== 32'h0000_1234 || bus.wb_data !== 32'h0000_1234) begin
         errors++;
         $display("FAIL alu_bypass: got rs=%h wb=%h expected 00001234", bus.rs_data, bus.wb_data);
      end
      checks++;
      if (bus.rt_data !== 32'h0 || dbg_data !== 32'h0) begin
         errors++;
         $display("FAIL alu_pre_edge: got rt=%h dbg=%h expected 0", bus.rt_data, dbg_data);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      checks++;
      if (dbg_data !== 32'h0000_1234 || wb_count !== 32'd1) begin
         errors++;
         $display("FAIL alu_commit: got dbg=%h count=%h expected 00001234 / 1", dbg_data, wb_count);
      end
   endtask

   task automatic test_load_writeback();
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31);
      bus.rs_addr = 5'd31;
      dbg_addr    = 5'd31;
      #1;
      checks++;
      if (bus.wb_data !== 32'hDEAD_BEEF || bus.rs_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL load_wb_data: got wb=%h rs=%h expected deadbeef", bus.wb_data, bus.rs_data);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      checks++;
      if (dbg_data !== 32'hDEAD_BEEF || bus.rs_data !== 32'hDEAD_BEEF || wb_count !== exp_count) begin
         errors++;
         $display("FAIL load_commit: got dbg=%h rs=%h count=%h expected deadbeef / %h",
                  dbg_data, bus.rs_data, wb_count, exp_count);
      end
   endtask

   task automatic test_r0_protection();
      drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
      bus.rs_addr = 5'd0;
      bus.rt_addr = 5'd0;
      dbg_addr    = 5'd0;
      #1;
      checks++;
      if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || bus.wb_data !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL r0_during: got rs=%h rt=%h wb=%h expected 0 / 0 / ffffffff",
                  bus.rs_data, bus.rt_data, bus.wb_data);
      end
      tick();
      checks++;
      if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || dbg_data !== 32'h0 || wb_count !== exp_count) begin
         errors++;
         $display("FAIL r0_after: got rs=%h rt=%h dbg=%h count=%h expected 0 0 0 %h",
                  bus.rs_data, bus.rt_data, dbg_data, wb_count, exp_count);
      end
   endtask

   task automatic test_dual_bypass();
      drive(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7);
      bus.rs_addr = 5'd7;
      bus.rt_addr = 5'd7;
      #1;
      checks++;
      if (bus.rs_data !== 32'hA5A5_A5A5 || bus.rt_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL dual_bypass: got rs=%h rt=%h expected a5a5a5a5", bus.rs_data, bus.rt_data);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd7);
      dbg_addr = 5'd7;
      #1;
      checks++;
      if (bus.rs_data !== 32'hA5A5_A5A5 || bus.rt_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL disabled_no_bypass: got rs=%h rt=%h expected a5a5a5a5", bus.rs_data, bus.rt_data);
      end
      tick();
      checks++;
      if (dbg_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL disabled_write: got r7=%h expected a5a5a5a5", dbg_data);
      end
   endtask

   task automatic test_random(input int n);
      reg_idx_t dst;
      for (int k = 0; k < n; k++) begin
         dst = reg_idx_t'($urandom_range(0, NREGS - 1));
         drive(1'($urandom), 1'($urandom), $urandom, $urandom, dst);
         bus.rs_addr = ($urandom_range(0, 1) == 0) ? dst : reg_idx_t'($urandom);
         bus.rt_addr = ($urandom_range(0, 1) == 0) ? dst : reg_idx_t'($urandom);
         dbg_addr    = ($urandom_range(0, 2) == 0) ? dst : reg_idx_t'($urandom);
         #1;
         checks++;
         if (bus.wb_data !== exp_wb()) begin
            errors++;
            $display("FAIL rand_wb_data[%0d]: got %h expected %h", k, bus.wb_data, exp_wb());
         end
         checks++;
         if (bus.rs_data !== exp_read(bus.rs_addr) || bus.rt_data !== exp_read(bus.rt_addr)) begin
            errors++;
            $display("FAIL rand_read[%0d]: got rs=%h rt=%h expected %h %h", k,
                     bus.rs_data, bus.rt_data, exp_read(bus.rs_addr), exp_read(bus.rt_addr));
         end
         checks++;
         if (dbg_data !== model[dbg_addr]) begin
            errors++;
            $display("FAIL rand_dbg_pre[%0d]: got %h expected %h", k, dbg_data, model[dbg_addr]);
         end
         tick();
         checks++;
         if (dbg_data !== model[dbg_addr] || wb_count !== exp_count) begin
            errors++;
            $display("FAIL rand_commit[%0d]: got dbg=%h count=%h expected %h %h", k,
                     dbg_data, wb_count, model[dbg_addr], exp_count);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic test_counter_wrap();
      force dut.wb_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.wb_count_q;
      exp_count = 32'hFFFF_FFFE;
      #1;
      checks++;
      if (wb_count !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL wrap_preset: got %h expected fffffffe", wb_count);
      end
      drive(1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd10);
      tick();
      checks++;
      if (wb_count !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_max: got %h expected ffffffff", wb_count);
      end
      tick();
      checks++;
      if (wb_count !== 32'h0 || exp_count !== 32'h0) begin
         errors++;
         $display("FAIL wrap_zero: got %h expected 00000000", wb_count);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic test_midop_reset();
      drive(1'b1, 1'b0, 32'h0, 32'h0000_3333, 5'd3);
      dbg_addr = 5'd3;
      tick();
      checks++;
      if (dbg_data !== 32'h0000_3333) begin
         errors++;
         $display("FAIL midop_setup: got r3=%h expected 00003333", dbg_data);
      end
      // Write to r3 pending when reset hits between edges: it must be lost.
      drive(1'b1, 1'b0, 32'h0, 32'h0000_4444, 5'd3);
      #2;
      rst = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      checks++;
      if (dbg_data !== 32'h0 || wb_count !== 32'h0) begin
         errors++;
         $display("FAIL midop_reset: got r3=%h count=%h expected 0 / 0", dbg_data, wb_count);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if (dbg_data !== 32'h0000_4444 || wb_count !== 32'd1) begin
         errors++;
         $display("FAIL midop_first_write: got r3=%h count=%h expected 00004444 / 1", dbg_data, wb_count);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      bus.rs_addr = 5'd0;
      bus.rt_addr = 5'd0;
      dbg_addr    = 5'd0;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      test_reset();
      test_alu_writeback();
      test_load_writeback();
      test_r0_protection();
      test_dual_bypass();
      test_random(300);
      test_counter_wrap();
      test_midop_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
